// File: rtl/mux_ctrl_pkg.sv
// Shared definitions for the round-robin mux-select arbiter.
// Holds the FSM state encoding and the default sizing of the requester bank.
package mux_ctrl_pkg;

    localparam int NREQ_DEF  = 16;
    localparam int SEL_W_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping mod NREQ.
// Latency: combinational.
// Backpressure: none; pure function of req and ptr.
module rr_pick
    import mux_ctrl_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [NREQ-1:0]  rot;
    logic [SEL_W-1:0] off;

    // Rotating right by ptr puts the highest-priority requester at bit 0.
    always_comb begin
        rot = NREQ'({req, req} >> ptr);
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
    end

    // NREQ is a power of two, so the SEL_W-bit add wraps mod NREQ for free.
    assign idx = off + ptr;
    assign any = |req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the 16:1 mux select, holding each grant for up to MAX_BURST transfers.
// Latency: req sampled at edge n gives registered sel/gnt/valid at n+1; one idle bubble between grants.
// Backpressure: ready=0 holds sel/gnt/valid and the beat count; dropping req[sel] releases the grant.
module rr_mux_arbiter
    import mux_ctrl_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int SEL_W     = SEL_W_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             ready,
    output logic [SEL_W-1:0] sel,
    output logic [NREQ-1:0]  gnt,
    output logic             valid
);

    localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    state_t            state, state_n;
    logic [SEL_W-1:0]  ptr, ptr_n;
    logic [BEAT_W-1:0] beats, beats_n;
    logic [SEL_W-1:0]  sel_n;
    logic [NREQ-1:0]   gnt_n;
    logic              valid_n;

    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;
    logic              xfer;
    logic              last;
    logic              drop;

    rr_pick #(
        .NREQ  (NREQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign xfer = valid & ready;
    assign last = xfer && (beats == BEAT_W'(MAX_BURST - 1));
    assign drop = ~req[sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            beats <= '0;
            sel   <= '0;
            gnt   <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            beats <= beats_n;
            sel   <= sel_n;
            gnt   <= gnt_n;
            valid <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        beats_n = beats;
        sel_n   = sel;
        gnt_n   = gnt;
        valid_n = valid;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n = GRANT;
                    sel_n   = pick_idx;
                    gnt_n   = NREQ'(1) << pick_idx;
                    valid_n = 1'b1;
                    beats_n = '0;
                end
            end
            GRANT: begin
                // Burst end and request drop on the same edge is a single release.
                if (last || drop) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    valid_n = 1'b0;
                    ptr_n   = sel + SEL_W'(1);
                    beats_n = '0;
                end else if (xfer) begin
                    beats_n = beats + BEAT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: expected grants queued at stimulus time,
// popped and compared by a negedge monitor as grants appear and release.
module tb_rr_mux_arbiter;

    localparam int NREQ      = 16;
    localparam int SEL_W     = 4;
    localparam int MAX_BURST = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req;
    logic             ready;
    logic [SEL_W-1:0] sel;
    logic [NREQ-1:0]  gnt;
    logic             valid;

    typedef struct {
        int idx;     // expected granted requester
        int nbeats;  // expected transfers before release
        int gap;     // expected idle cycles before this grant, -1 = don't care
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   nchk = 0;
    int   nerr = 0;
    bit   in_grant = 1'b0;
    int   beat_cnt = 0;
    int   gap_cnt  = 0;

    rr_mux_arbiter #(
        .NREQ      (NREQ),
        .SEL_W     (SEL_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .ready (ready),
        .sel   (sel),
        .gnt   (gnt),
        .valid (valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int idx, input int nbeats, input int gap);
        exp_t e;
        e.idx    = idx;
        e.nbeats = nbeats;
        e.gap    = gap;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Returns at the bubble after the last queued grant has been released.
    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (exp_q.size() == 0 && !in_grant) return;
        end
        chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            in_grant = 1'b0;
            gap_cnt  = 0;
        end else begin
            if (valid && !in_grant) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_grant", {28'd0, sel}, 32'hFFFF_FFFF);
                    cur.idx    = 0;
                    cur.nbeats = 0;
                    cur.gap    = -1;
                end else begin
                    cur = exp_q.pop_front();
                    chk("grant_sel", {28'd0, sel}, cur.idx);
                    if (cur.gap >= 0) chk("bubble_len", gap_cnt, cur.gap);
                end
                in_grant = 1'b1;
                beat_cnt = 0;
            end
            if (valid) begin
                chk("gnt_onehot", {16'd0, gnt}, 32'd1 << cur.idx);
                if (ready) beat_cnt++;
            end else if (in_grant) begin
                chk("burst_len", beat_cnt, cur.nbeats);
                chk("gnt_idle", {16'd0, gnt}, 32'd0);
                in_grant = 1'b0;
                gap_cnt  = 0;
            end
            if (!valid) gap_cnt++;
        end
    end

    initial begin
        rst   = 1'b1;
        req   = '0;
        ready = 1'b0;
        #2;
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_sel",   {28'd0, sel},   32'd0);
        chk("rst_gnt",   {16'd0, gnt},   32'd0);
        step();
        rst = 1'b0;
        step();

        // Reset mid-burst: outputs clear without a clock edge, ptr restarts at 0.
        push(2, 0, -1);
        req = 16'h0004;
        step();
        chk("pre_rst_valid", {31'd0, valid}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, valid}, 32'd0);
        chk("async_rst_sel",   {28'd0, sel},   32'd0);
        chk("async_rst_gnt",   {16'd0, gnt},   32'd0);
        push(0, 4, -1);
        req   = 16'h8001;
        ready = 1'b1;
        #1;
        rst = 1'b0;
        wait_idle(100);
        req = '0;

        // Single requester: latency, full burst, one bubble, re-grant.
        push(5, 4, -1);
        push(5, 4, 1);
        req = 16'h0020;
        step();
        chk("single_valid", {31'd0, valid}, 32'd1);
        chk("single_sel",   {28'd0, sel},   32'd5);
        chk("single_gnt",   {16'd0, gnt},   32'h0020);
        wait_idle(100);
        req = '0;

        // Round robin from a fresh reset: 0..15 then 0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i <= NREQ; i++) begin
            push(i % NREQ, 4, (i == 0) ? -1 : 1);
        end
        req = 16'hFFFF;
        wait_idle(300);
        req = '0;

        // Wrap search: after 14, req 0009 must pick 0 before 3.
        push(14, 4, -1);
        req = 16'h4000;
        wait_idle(100);
        push(0, 4, 1);
        req = 16'h0009;
        wait_idle(100);
        req = '0;

        // Backpressure then early drop: no beats counted, ptr moves to 3.
        ready = 1'b0;
        push(2, 0, -1);
        req = 16'h0004;
        step();
        chk("bp_valid_0", {31'd0, valid}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("bp_hold_valid", {31'd0, valid}, 32'd1);
            chk("bp_hold_sel",   {28'd0, sel},   32'd2);
        end
        req = '0;
        step();
        chk("drop_valid", {31'd0, valid}, 32'd0);
        chk("drop_gnt",   {16'd0, gnt},   32'd0);
        push(0, 4, 1);
        ready = 1'b1;
        req   = 16'h0005;
        wait_idle(100);
        req = '0;

        // Drop on the 4th transfer: single release, ptr = 9.
        push(8, 4, -1);
        req = 16'h0100;
        for (int i = 0; i < 4; i++) step();
        req = '0;
        step();
        chk("simrel_valid", {31'd0, valid}, 32'd0);
        push(9, 4, 1);
        req = 16'h0300;
        wait_idle(100);
        req = '0;

        step();
        step();
        chk("end_idle_valid", {31'd0, valid}, 32'd0);
        chk("end_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares the 16:1 bit-select mux among 16 requesters.
- Picks one requester, drives the mux select, and holds the grant for a bounded burst of transfers.
- The downstream consumer accepts each transfer with a valid/ready handshake; then the grant rotates.
- Sits between the requester bank and the mux select input; the mux output is the data bit for the granted requester.

Parameters:
- NREQ, 16, number of requesters and mux inputs; must be a power of 2.
- SEL_W, 4, select width; must equal log2(NREQ).
- MAX_BURST, 4, maximum accepted transfers per grant; must be ≥1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- req  input  NREQ  per-requester request, level-sensitive.
- ready  input  1  consumer accepts the current mux output this cycle.
- sel  output  SEL_W  registered mux select (index of the granted requester).
- gnt  output  NREQ  registered one-hot grant; all-zero when idle.
- valid  output  1  registered; mux output is meaningful this cycle.

Behaviour:
- Reset (async, rst=1): state=IDLE, sel=0, gnt=0, valid=0, rotate pointer ptr=0, beat counter=0. Outputs clear immediately, not at the next edge.
- States: IDLE, GRANT. All outputs are registered.
- IDLE:
  - If req≠0 at a clock edge: winner = first set bit of req searching ptr, ptr+1, … wrapping mod NREQ.
  - Load sel=winner, gnt=1<<winner, valid=1, beats=0; go to GRANT.
  - Latency: req sampled at edge n gives valid/gnt at n+1.
  - If req=0, stay in IDLE with outputs 0.
- GRANT:
  - A transfer occurs at an edge where valid=1 and ready=1; each transfer increments beats.
  - Release at an edge if either:
    - (a) a transfer occurs and beats==MAX_BURST-1, or
    - (b) req[sel]=0, sampled at that edge.
  - On release: state=IDLE, gnt=0, valid=0, ptr=(sel+1) mod NREQ, beats=0. sel keeps its old value; do not rely on it while valid=0.
  - When (a) and (b) happen at the same edge, the transfer still counts and the release is taken once.
  - When (b) happens without ready, no transfer is counted for that cycle.
  - Otherwise hold sel/gnt/valid; beats unchanged if ready=0.
- Release always passes through IDLE, so there is one bubble cycle between grants. Maximum throughput is MAX_BURST transfers per MAX_BURST+1 cycles under contention.
- Fairness: after a release, the released requester has lowest priority. With all requesters active, grants cycle 0,1,…,15,0.
- Wrap-around: ptr increment and search are mod NREQ. sel=15 on release gives ptr=0.
- Requests other than req[sel] have no effect in GRANT.
- gnt is always the one-hot decode of sel when valid=1, and 0 when valid=0.
- The beat counter width is ceil(log2(MAX_BURST)), minimum 1. MAX_BURST=1 releases on every transfer.
- Reset asserted mid-burst aborts the burst. No transfer is counted at that edge, and after reset the first grant searches from index 0.

Decomposition:
- Shared package/header mux_ctrl_pkg:
  - state encoding constants IDLE=1'b0, GRANT=1'b1;
  - default NREQ=16, SEL_W=4.
- One combinational sub-module rr_pick (inputs req, ptr; outputs idx, any).
  - Implementation: rotate req right by ptr, apply a priority encoder, add ptr back mod NREQ.
  - Unit-testable on its own.
- The top level holds the FSM, ptr, beat counter and output registers.

Test Plan:
- Reset mid-burst: rst pulsed while valid=1 and mid-cycle → sel/gnt/valid go to 0 without a clock edge. After release, req=16'h8001 → grant index 0 (ptr back at 0).
- Single requester: req=16'h0020 held, ready=1, MAX_BURST=4.
  - Edge after req gives sel=5, gnt=16'h0020, valid=1.
  - Exactly 4 transfers, then one valid=0 cycle, then a re-grant to 5.
- Round-robin:
  - req=16'hFFFF, ready=1 constant → grant sequence 0,1,2,…,15,0.
  - Each grant lasts 4 valid cycles with a 1-cycle bubble.
  - gnt is always one-hot of sel.
- Wrap search: grant to 14 completes, then req=16'h0009 → next grant is 0, not 3.
- Backpressure plus early drop:
  - Grant to 2 with ready=0 for 3 cycles → beats stay 0 and valid stays 1.
  - Deassert req[2] with ready=0 → valid=0 at the next edge, no transfer counted, ptr=3.
- Simultaneous release: on the 4th transfer, req[sel] is also dropped at the same edge → single release, ptr=sel+1, no extra bubble or double advance.
